// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button debounce, IDLE/WAIT/CNT/STOP sequencer, count-tick divider.
// Optional auto-stop after MAX_TICKS ticks is built when STOPWATCH_AUTO_STOP_EN is defined.
module stopwatch_ctrl #(
    parameter int DB_CYCLES = 500_000,
    parameter int TICK_DIV  = 1_000_000,
    parameter int MAX_TICKS = 360_000
) (
    input  logic       clk100Mhz,
    input  logic       rst,
    input  logic [2:0] btnRaw,
    output logic       cnt_clr,
    output logic       cnt_en,
    output logic       tick,
    output logic       ovf,
    output logic [2:0] led
);

    localparam int DBW  = $clog2(DB_CYCLES + 1);
    localparam int DIVW = $clog2(TICK_DIV);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic [2:0] press;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_db
            logic           sync1_reg;
            logic           sync2_reg;
            logic           level_reg;
            logic           press_reg;
            logic [DBW-1:0] cnt_reg;

            // press fires on the same edge the debounced level rises
            always_ff @(posedge clk100Mhz) begin
                if (rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btnRaw[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DBW'(DB_CYCLES - 1)) begin
                        level_reg <= sync2_reg;
                        press_reg <= sync2_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    logic [1:0]      state_reg, state_next;
    logic [DIVW-1:0] div_reg, div_next;
    logic            clr_next, tick_next, ovf_next;
    logic            wrap;
    logic            last_tick;
    logic            stop_lock;

    assign wrap = (div_reg == DIVW'(TICK_DIV - 1));

`ifdef STOPWATCH_AUTO_STOP_EN
    localparam int TCW = $clog2(MAX_TICKS + 1);
    logic [TCW-1:0] tcnt_reg;

    always_ff @(posedge clk100Mhz) begin
        if (rst || clr_next) begin
            tcnt_reg <= '0;
        end else if (tick_next) begin
            tcnt_reg <= tcnt_reg + 1'b1;
        end
    end

    assign last_tick = (tcnt_reg == TCW'(MAX_TICKS - 1));
    assign stop_lock = (tcnt_reg == TCW'(MAX_TICKS));
`else
    assign last_tick = 1'b0;
    assign stop_lock = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        clr_next   = 1'b0;
        tick_next  = 1'b0;
        ovf_next   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (press[0]) begin
                    state_next = S_WAIT;
                    clr_next   = 1'b1;
                end
            end
            S_WAIT: begin
                if (press[1]) begin
                    state_next = S_CNT;
                end
            end
            S_CNT: begin
                if (wrap && last_tick) begin
                    state_next = S_STOP;
                    div_next   = '0;
                    tick_next  = 1'b1;
                    ovf_next   = 1'b1;
                end else if (press[1]) begin
                    // a stop landing on the wrap cycle keeps the pending tick for resume
                    state_next = S_STOP;
                    if (!wrap) begin
                        div_next = div_reg + 1'b1;
                    end
                end else if (wrap) begin
                    div_next  = '0;
                    tick_next = 1'b1;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            S_STOP: begin
                if (press[2]) begin
                    state_next = S_WAIT;
                    clr_next   = 1'b1;
                end else if (press[1] && !stop_lock) begin
                    state_next = S_CNT;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (clr_next) begin
            div_next = '0;
        end
    end

    always_ff @(posedge clk100Mhz) begin
        if (rst) begin
            state_reg <= S_IDLE;
            div_reg   <= '0;
            cnt_clr   <= 1'b0;
            cnt_en    <= 1'b0;
            tick      <= 1'b0;
            ovf       <= 1'b0;
            led       <= 3'b000;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            cnt_clr   <= clr_next;
            cnt_en    <= (state_next == S_CNT);
            tick      <= tick_next;
            ovf       <= ovf_next;
            case (state_next)
                S_WAIT:  led <= 3'b001;
                S_CNT:   led <= 3'b010;
                S_STOP:  led <= 3'b100;
                default: led <= 3'b000;
            endcase
        end
    end

endmodule
